left_shift_pipe: RTL and testbench

//  32-bit logical-left barrel shifter, one shift level per pipeline stage.

---
 rtl/left_shift_pipe_if.sv | 30 +++
 rtl/left_shift_pipe.sv | 131 +++++++++++++
 tb/tb_left_shift_pipe.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/left_shift_pipe_if.sv
// Operation/result bus of the left-shift pipeline.
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both 1; the source holds its payload stable while valid=1 and ready=0.
interface left_shift_pipe_if #(
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic [4:0]       in_shamt;
  logic             in_rot;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  // Producer of operations / consumer of results.
  modport master (
    output in_valid, in_data, in_shamt, in_rot, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_ovf, out_tag
  );

  // The shifter itself.
  modport slave (
    input  in_valid, in_data, in_shamt, in_rot, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_ovf, out_tag
  );
endinterface

// File: rtl/left_shift_pipe.sv
// 32-bit logical-left barrel shifter, one level per stage (16, 8, 4, 2, 1).
// Five register stages, 1 op/cycle, global stall: every stage advances
// together when S5 is empty or its result is taken.
// out_ovf is the sticky OR of every '1' bit pushed past bit 31.
// Optional macro LSHIFT_ROTATE_EN: in_rot=1 selects rotate-left (ovf forced 0);
// without it in_rot is ignored and no rotate bit is carried.
module left_shift_pipe #(
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  left_shift_pipe_if.slave  bus
);

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
  } lvl_t;

  // One shift level of width l; bits leaving the top either wrap (rotate)
  // or set the overflow flag.
  function automatic lvl_t shift_level(input logic [31:0] d, input logic ovf,
                                       input logic en, input logic rot,
                                       input int l);
    lvl_t        r;
    logic [31:0] hi;
    hi     = d >> (32 - l);
    r.data = d;
    r.ovf  = ovf;
    if (en) begin
      r.data = (d << l) | (rot ? hi : 32'd0);
      r.ovf  = ovf | ((|hi) & ~rot);
    end
    return r;
  endfunction

  logic             v1, v2, v3, v4, v5;
  logic [31:0]      d1, d2, d3, d4, d5;
  logic             o1, o2, o3, o4, o5;
  logic [TAG_W-1:0] t1, t2, t3, t4, t5;
  logic [3:0]       sh1;
  logic [2:0]       sh2;
  logic [1:0]       sh3;
  logic             sh4;
  logic             r0, r1, r2, r3, r4;
  logic             adv;
  lvl_t             n1, n2, n3, n4, n5;

  assign adv          = ~v5 | bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid = v5;
  assign bus.out_data  = d5;
  assign bus.out_ovf   = o5;
  assign bus.out_tag   = t5;

  assign n1 = shift_level(bus.in_data, 1'b0, bus.in_shamt[4], r0, 16);
  assign n2 = shift_level(d1, o1, sh1[3], r1, 8);
  assign n3 = shift_level(d2, o2, sh2[2], r2, 4);
  assign n4 = shift_level(d3, o3, sh3[1], r3, 2);
  assign n5 = shift_level(d4, o4, sh4,    r4, 1);

`ifdef LSHIFT_ROTATE_EN
  assign r0 = bus.in_rot;

  // Rotate select travels with its operation through S1..S4.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r1 <= 1'b0;
      r2 <= 1'b0;
      r3 <= 1'b0;
      r4 <= 1'b0;
    end else if (adv) begin
      r1 <= r0;
      r2 <= r1;
      r3 <= r2;
      r4 <= r3;
    end
  end
`else
  logic unused_rot;
  assign unused_rot = bus.in_rot;
  assign r0 = 1'b0;
  assign r1 = 1'b0;
  assign r2 = 1'b0;
  assign r3 = 1'b0;
  assign r4 = 1'b0;
`endif

  // Pipeline stages: all load from their predecessor on adv, otherwise hold.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0; v5 <= 1'b0;
      d1 <= '0;   d2 <= '0;   d3 <= '0;   d4 <= '0;   d5 <= '0;
      o1 <= 1'b0; o2 <= 1'b0; o3 <= 1'b0; o4 <= 1'b0; o5 <= 1'b0;
      t1 <= '0;   t2 <= '0;   t3 <= '0;   t4 <= '0;   t5 <= '0;
      sh1 <= '0;  sh2 <= '0;  sh3 <= '0;  sh4 <= 1'b0;
    end else if (adv) begin
      // in_ready equals adv here, so the accept condition reduces to in_valid.
      v1  <= bus.in_valid;
      d1  <= n1.data;
      o1  <= n1.ovf;
      t1  <= bus.in_tag;
      sh1 <= bus.in_shamt[3:0];

      v2  <= v1;
      d2  <= n2.data;
      o2  <= n2.ovf;
      t2  <= t1;
      sh2 <= sh1[2:0];

      v3  <= v2;
      d3  <= n3.data;
      o3  <= n3.ovf;
      t3  <= t2;
      sh3 <= sh2[1:0];

      v4  <= v3;
      d4  <= n4.data;
      o4  <= n4.ovf;
      t4  <= t3;
      sh4 <= sh3[0];

      v5  <= v4;
      d5  <= n5.data;
      o5  <= n5.ovf;
      t5  <= t4;
    end
  end

endmodule

// File: tb/tb_left_shift_pipe.sv
// Bench for left_shift_pipe: directed literal cases, stall, reset and a
// randomized stream checked every cycle against a behavioural model.
module tb_left_shift_pipe;

  logic clk;
  logic n_rst;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_out = 0;
  logic rand_rdy = 1'b0;

  // Model state: expected {data, ovf, tag} per op plus how many pipeline
  // advances each op has experienced (5 = sitting at the output).
  logic [36:0] exp_q[$];
  int          age_q[$];

  left_shift_pipe_if #(.TAG_W(4)) bus ();

  left_shift_pipe #(.TAG_W(4)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference ----------------
  function automatic logic [36:0] ref_op(input logic [31:0] d, input logic [4:0] sh,
                                         input logic rot, input logic [3:0] t);
    logic [63:0] w;
    logic [31:0] res;
    logic        ovf;
    w = {32'd0, d} << sh;
    if (rot) begin
      res = w[31:0] | w[63:32];
      ovf = 1'b0;
    end else begin
      res = w[31:0];
      ovf = |w[63:32];
    end
    return {res, ovf, t};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_valid();
    return (age_q.size() > 0) && (age_q[0] == 5);
  endfunction

  // Model: advance when the output slot is empty or being taken.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      exp_q.delete();
      age_q.delete();
    end else begin
      logic head_out, adv_m, rot_m;
      head_out = model_valid();
      adv_m    = !head_out || bus.out_ready;
      if (adv_m) begin
        if (head_out) begin
          void'(exp_q.pop_front());
          void'(age_q.pop_front());
          n_out++;
        end
        foreach (age_q[i]) age_q[i] = age_q[i] + 1;
        if (bus.in_valid) begin
`ifdef LSHIFT_ROTATE_EN
          rot_m = bus.in_rot;
`else
          rot_m = 1'b0;
`endif
          exp_q.push_back(ref_op(bus.in_data, bus.in_shamt, rot_m, bus.in_tag));
          age_q.push_back(1);
        end
      end
    end
  end

  // Scoreboard compare, every cycle away from the active edge.
  always @(negedge clk) begin
    if (n_rst) begin
      logic ev;
      ev = model_valid();
      chk("out_valid", bus.out_valid, ev);
      chk("in_ready", bus.in_ready, !ev || bus.out_ready);
      if (ev && bus.out_valid)
        chk("result", {bus.out_data, bus.out_ovf, bus.out_tag}, exp_q[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic r,
                      input logic [3:0] t, output int tries);
    logic acc;
    bus.in_data  = d;
    bus.in_shamt = sh;
    bus.in_rot   = r;
    bus.in_tag   = t;
    bus.in_valid = 1'b1;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      tries++;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    chk(name, bus.out_valid, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int tries;
    int base;
    logic [31:0] d;
    n_rst        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_shamt = '0;
    bus.in_rot   = 1'b0;
    bus.in_tag   = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_ovf", bus.out_ovf, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    n_rst = 1'b1;
    tick();

    // 1: latency and shamt=31
    send(32'h0000_0001, 5'd31, 1'b0, 4'd3, tries);
    repeat (3) tick();
    chk("lat_early", bus.out_valid, 0);
    tick();
    chk("lat_valid", bus.out_valid, 1);
    chk("t1_data", bus.out_data, 32'h8000_0000);
    chk("t1_ovf", bus.out_ovf, 0);
    chk("t1_tag", bus.out_tag, 3);
    tick();

    // 2: overflow and shamt=0, back to back
    send(32'hF000_000F, 5'd4, 1'b0, 4'd5, tries);
    send(32'hF000_000F, 5'd0, 1'b0, 4'd6, tries);
    wait_valid("t2_wait");
    chk("t2a_data", bus.out_data, 32'h0000_00F0);
    chk("t2a_ovf", bus.out_ovf, 1);
    tick();
    chk("t2b_data", bus.out_data, 32'hF000_000F);
    chk("t2b_ovf", bus.out_ovf, 0);
    chk("t2b_tag", bus.out_tag, 6);
    drain("t2_drain");

    // shamt=31 with upper bits set
    send(32'h7FFF_FFFF, 5'd31, 1'b0, 4'd9, tries);
    wait_valid("t31_wait");
    chk("t31_data", bus.out_data, 32'h8000_0000);
    chk("t31_ovf", bus.out_ovf, 1);
    drain("t31_drain");

    // 3: back-to-back stream, shamt 0..31
    base = n_out;
    for (int i = 0; i < 32; i++) begin
      d = $urandom();
      send(d, i[4:0], 1'b0, i[3:0], tries);
      chk("b2b_ready", tries, 1);
    end
    drain("b2b_drain");
    chk("b2b_count", n_out - base, 32);

    // 4: stall with full pipe
    bus.out_ready = 1'b0;
    base = n_out;
    for (int i = 0; i < 5; i++) begin
      send($urandom(), 5'($urandom_range(0, 31)), 1'b0, 4'(i + 10), tries);
      chk("fill_ready", tries, 1);
    end
    bus.in_data  = 32'h1234_5678;
    bus.in_shamt = 5'd8;
    bus.in_tag   = 4'd15;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_tag", bus.out_tag, 10);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain("stall_drain");
    chk("stall_count", n_out - base, 6);

`ifdef LSHIFT_ROTATE_EN
    // 6: rotate versus shift
    send(32'h8000_0001, 5'd1, 1'b1, 4'd7, tries);
    send(32'h8000_0001, 5'd1, 1'b0, 4'd8, tries);
    wait_valid("rot_wait");
    chk("rot_data", bus.out_data, 32'h0000_0003);
    chk("rot_ovf", bus.out_ovf, 0);
    tick();
    chk("shl_data", bus.out_data, 32'h0000_0002);
    chk("shl_ovf", bus.out_ovf, 1);
    drain("rot_drain");
`endif

    // Randomized stream with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send($urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), tries);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    rand_rdy = 1'b0;
    bus.out_ready = 1'b1;
    drain("rand_drain");

    // 5: reset mid-stream with operations in flight
    for (int i = 0; i < 6; i++) send($urandom(), 5'($urandom_range(0, 31)), 1'b0, 4'(i), tries);
    chk("pre_rst_valid", bus.out_valid, 1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_out_tag", bus.out_tag, 0);
    chk("mid_rst_out_ovf", bus.out_ovf, 0);
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (10) tick();
    chk("post_rst_valid", bus.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
